mem_stage_ctrl: RTL and testbench

- Memory-stage controller that produces the MEM/WB latch inputs.
- Takes the EX/MEM memory operation and runs the load/store/LL/SC handshake with the data cache.
- Stalls upstream stages while a request is outstanding.
- Drives the MEM/WB enable, load-data and halt fields; holds the per-core LL/SC link register and a completed-access counter.

---
 rtl/mem_stage_ctrl.sv | 117 +++++++++++
 tb/tb_mem_stage_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage load/store/LL/SC handshake with the data cache, feeding the MEM/WB latch
module mem_stage_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             em_valid,
    input  logic             em_memread,
    input  logic             em_memwrite,
    input  logic             em_ll,
    input  logic             em_sc,
    input  logic             em_halt,
    input  logic [31:0]      em_addr,
    input  logic [31:0]      em_store,
    input  logic             dhit,
    input  logic [31:0]      dmem_load,
    input  logic             snoop_inv,
    input  logic [31:0]      snoop_addr,
    output logic             dmem_ren,
    output logic             dmem_wen,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_store,
    output logic             stall_o,
    output logic             mw_enable,
    output logic [31:0]      mw_dload,
    output logic             halt_o,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] wait_cnt
);
    typedef enum logic [1:0] {IDLE, ACCESS, HALTED} state_t;
    state_t state, state_n;
    logic rd_q, wr_q, ll_q, sc_q, link_valid, mem_op, sc_fail, start, done;
    logic [31:0] addr_q, data_q, dload_q, link_addr;
    assign halt_o = state == HALTED;
    // next state, cache requests and MEM/WB handshake
    always_comb begin
        mem_op     = em_valid && (em_memread || em_memwrite);
        sc_fail    = em_valid && em_memwrite && em_sc && (!link_valid || link_addr != em_addr);
        start      = state == IDLE && mem_op && !sc_fail;
        done       = state == ACCESS && dhit;
        state_n    = state;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = '0;
        dmem_store = '0;
        stall_o    = 1'b0;
        mw_enable  = 1'b0;
        mw_dload   = dload_q;
        case (state)
            IDLE: begin
                stall_o   = start;
                mw_enable = !start;
                mw_dload  = sc_fail ? 32'd0 : dload_q;
                state_n   = start ? ACCESS : (em_valid && em_halt) ? HALTED : IDLE;
            end
            ACCESS: begin
                dmem_ren   = rd_q;
                dmem_wen   = wr_q;
                dmem_addr  = addr_q;
                dmem_store = data_q;
                stall_o    = !dhit;
                mw_enable  = dhit;
                mw_dload   = !dhit ? dload_q : rd_q ? dmem_load : sc_q ? 32'd1 : dload_q;
                state_n    = dhit ? IDLE : ACCESS;
            end
            HALTED: stall_o = 1'b1;
            default: state_n = IDLE;
        endcase
    end
    // state, captured operation and held MEM/WB load data
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ll_q    <= 1'b0;
            sc_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            dload_q <= '0;
        end else begin
            state   <= state_n;
            dload_q <= mw_dload;
            if (start) begin
                rd_q   <= em_memread;
                wr_q   <= em_memwrite;
                ll_q   <= em_ll;
                sc_q   <= em_sc;
                addr_q <= em_addr;
                data_q <= em_store;
            end
        end
    end
    // LL/SC link; a snoop on the line being linked this cycle wins over the set
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (done && ll_q) begin
            link_valid <= !(snoop_inv && snoop_addr == addr_q);
            link_addr  <= addr_q;
        end else if ((done && sc_q) || (done && wr_q && addr_q == link_addr) ||
                     (snoop_inv && snoop_addr == link_addr)) begin
            link_valid <= 1'b0;
        end
    end
    // saturating completed-access and wait-cycle counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            if (done && acc_cnt != '1) acc_cnt <= acc_cnt + 1'b1;
            if (state == ACCESS && !dhit && wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: vector table, directed corner sequences and a random run against a reference model
module tb_mem_stage_ctrl;
    logic CLK = 1'b0, nRST = 1'b0;
    logic em_valid, em_memread, em_memwrite, em_ll, em_sc, em_halt, dhit, snoop_inv;
    logic [31:0] em_addr, em_store, dmem_load, snoop_addr;
    logic dmem_ren, dmem_wen, stall_o, mw_enable, halt_o;
    logic [31:0] dmem_addr, dmem_store, mw_dload;
    logic [15:0] acc_cnt, wait_cnt;
    int checks = 0, failures = 0;
    int cur_op;

    mem_stage_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .em_valid(em_valid), .em_memread(em_memread),
        .em_memwrite(em_memwrite), .em_ll(em_ll), .em_sc(em_sc), .em_halt(em_halt),
        .em_addr(em_addr), .em_store(em_store), .dhit(dhit), .dmem_load(dmem_load),
        .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .dmem_ren(dmem_ren),
        .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_store(dmem_store),
        .stall_o(stall_o), .mw_enable(mw_enable), .mw_dload(mw_dload), .halt_o(halt_o),
        .acc_cnt(acc_cnt), .wait_cnt(wait_cnt)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        int op;
        logic [31:0] a, d;
        logic dh;
        logic [31:0] ld;
        logic si;
        logic [31:0] sa;
        logic er, ew, es, em;
        logic [31:0] edl;
    } vec_t;
    vec_t tv[$];

    // reference model state
    logic m_busy, m_lv;
    int m_op, m_acc, m_wait;
    logic [31:0] m_a, m_d, m_la, m_dl;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // op: 0 none, 1 LW, 2 SW, 3 LL, 4 SC, 5 HALT
    task automatic drive(int op, logic [31:0] a, logic [31:0] d, logic dh, logic [31:0] ld,
                         logic si, logic [31:0] sa);
        cur_op      = op;
        em_valid    = op != 0;
        em_memread  = op == 1 || op == 3;
        em_memwrite = op == 2 || op == 4;
        em_ll       = op == 3;
        em_sc       = op == 4;
        em_halt     = op == 5;
        em_addr     = a;
        em_store    = d;
        dhit        = dh;
        dmem_load   = ld;
        snoop_inv   = si;
        snoop_addr  = sa;
    endtask

    function automatic vec_t v(int op, logic [31:0] a, logic [31:0] d, logic dh, logic [31:0] ld,
                               logic si, logic [31:0] sa, logic er, logic ew, logic es,
                               logic em, logic [31:0] edl);
        vec_t r;
        r.op = op; r.a = a; r.d = d; r.dh = dh; r.ld = ld; r.si = si; r.sa = sa;
        r.er = er; r.ew = ew; r.es = es; r.em = em; r.edl = edl;
        return r;
    endfunction

    task automatic do_reset();
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        chk("rst_ren", dmem_ren, 0);
        chk("rst_wen", dmem_wen, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_store", dmem_store, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_mwen", mw_enable, 1);
        chk("rst_dload", mw_dload, 0);
        chk("rst_halt", halt_o, 0);
        chk("rst_acc", acc_cnt, 0);
        chk("rst_wait", wait_cnt, 0);
        nRST = 1'b1;
        m_busy = 0; m_lv = 0; m_la = 0; m_dl = 0; m_acc = 0; m_wait = 0; m_op = 0;
        m_a = 0; m_d = 0;
    endtask

    // one cycle of the reference model: check current outputs, then advance
    task automatic model_step();
        logic memop, fail, isrd, iswr, lldone;
        chk("m_acc", acc_cnt, m_acc);
        chk("m_wait", wait_cnt, m_wait);
        lldone = 0;
        if (!m_busy) begin
            memop = em_valid && (em_memread || em_memwrite);
            fail  = em_valid && em_memwrite && em_sc && (!m_lv || m_la != em_addr);
            if (fail) m_dl = 0;
            chk("m_ren", dmem_ren, 0);
            chk("m_wen", dmem_wen, 0);
            chk("m_stall", stall_o, memop && !fail);
            chk("m_mwen", mw_enable, !(memop && !fail));
            chk("m_dload", mw_dload, m_dl);
            if (memop && !fail) begin
                m_busy = 1; m_op = cur_op; m_a = em_addr; m_d = em_store;
            end
        end else begin
            isrd = m_op == 1 || m_op == 3;
            iswr = m_op == 2 || m_op == 4;
            chk("m_ren", dmem_ren, isrd);
            chk("m_wen", dmem_wen, iswr);
            chk("m_addr", dmem_addr, m_a);
            chk("m_store", dmem_store, m_d);
            chk("m_stall", stall_o, !dhit);
            chk("m_mwen", mw_enable, dhit);
            if (dhit) begin
                if (isrd) m_dl = dmem_load;
                if (m_op == 4) m_dl = 1;
                if (m_acc < 65535) m_acc++;
                m_busy = 0;
                if (m_op == 3) begin
                    lldone = 1;
                    m_lv = !(snoop_inv && snoop_addr == m_a);
                    m_la = m_a;
                end
                if (m_op == 4) m_lv = 0;
                if (m_op == 2 && m_a == m_la) m_lv = 0;
            end else if (m_wait < 65535) m_wait++;
            chk("m_dload", mw_dload, m_dl);
        end
        if (!lldone && snoop_inv && snoop_addr == m_la) m_lv = 0;
    endtask

    initial begin
        tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tv.push_back(v(2, 32'h200, 32'h12345678, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(v(2, 32'h200, 32'h12345678, 1, 0, 0, 0, 0, 1, 0, 1, 0));
        tv.push_back(v(3, 32'h300, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(v(3, 32'h300, 0, 1, 32'hAAAA5555, 0, 0, 1, 0, 0, 1, 32'hAAAA5555));
        tv.push_back(v(4, 32'h300, 7, 0, 0, 0, 0, 0, 0, 1, 0, 32'hAAAA5555));
        tv.push_back(v(4, 32'h300, 7, 1, 0, 0, 0, 0, 1, 0, 1, 1));
        tv.push_back(v(4, 32'h300, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tv.push_back(v(3, 32'h300, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(v(3, 32'h300, 0, 1, 5, 0, 0, 1, 0, 0, 1, 5));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 32'h304, 0, 0, 0, 1, 5));
        tv.push_back(v(4, 32'h300, 8, 0, 0, 0, 0, 0, 0, 1, 0, 5));
        tv.push_back(v(4, 32'h300, 8, 1, 0, 1, 32'h300, 0, 1, 0, 1, 1));
        tv.push_back(v(3, 32'h400, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        tv.push_back(v(3, 32'h400, 0, 1, 32'h77, 1, 32'h400, 1, 0, 0, 1, 32'h77));
        tv.push_back(v(4, 32'h400, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tv.push_back(v(3, 32'h300, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(v(3, 32'h300, 0, 1, 9, 0, 0, 1, 0, 0, 1, 9));
        tv.push_back(v(0, 0, 0, 0, 0, 1, 32'h300, 0, 0, 0, 1, 9));
        tv.push_back(v(4, 32'h300, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tv.push_back(v(3, 32'h500, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(v(3, 32'h500, 0, 1, 3, 0, 0, 1, 0, 0, 1, 3));
        tv.push_back(v(2, 32'h500, 32'hABC, 0, 0, 0, 0, 0, 0, 1, 0, 3));
        tv.push_back(v(2, 32'h500, 32'hABC, 1, 0, 0, 0, 0, 1, 0, 1, 3));
        tv.push_back(v(4, 32'h500, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].op, tv[i].a, tv[i].d, tv[i].dh, tv[i].ld, tv[i].si, tv[i].sa);
            #3;
            chk($sformatf("tv%0d_ren", i), dmem_ren, tv[i].er);
            chk($sformatf("tv%0d_wen", i), dmem_wen, tv[i].ew);
            chk($sformatf("tv%0d_stall", i), stall_o, tv[i].es);
            chk($sformatf("tv%0d_mwen", i), mw_enable, tv[i].em);
            chk($sformatf("tv%0d_dload", i), mw_dload, tv[i].edl);
            if (tv[i].er || tv[i].ew) begin
                chk($sformatf("tv%0d_addr", i), dmem_addr, tv[i].a);
                if (tv[i].ew) chk($sformatf("tv%0d_store", i), dmem_store, tv[i].d);
            end
            tick();
        end

        // LW with three wait cycles before dhit
        do_reset();
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        #3;
        chk("lw_det_stall", stall_o, 1);
        chk("lw_det_ren", dmem_ren, 0);
        chk("lw_det_mwen", mw_enable, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("lw_wait_ren", dmem_ren, 1);
            chk("lw_wait_addr", dmem_addr, 32'h100);
            chk("lw_wait_stall", stall_o, 1);
            chk("lw_wait_mwen", mw_enable, 0);
            tick();
        end
        drive(1, 32'h100, 0, 1, 32'hDEADBEEF, 0, 0);
        #3;
        chk("lw_hit_ren", dmem_ren, 1);
        chk("lw_hit_stall", stall_o, 0);
        chk("lw_hit_mwen", mw_enable, 1);
        chk("lw_hit_dload", mw_dload, 32'hDEADBEEF);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("lw_after_dload", mw_dload, 32'hDEADBEEF);
        chk("lw_after_ren", dmem_ren, 0);
        chk("lw_wait_cnt", wait_cnt, 3);
        chk("lw_acc_cnt", acc_cnt, 1);
        tick();

        // randomized pipeline traffic against the model
        do_reset();
        begin
            int op = 0;
            logic [31:0] a = 0, d = 0;
            for (int i = 0; i < 600; i++) begin
                if (!m_busy) begin
                    op = $urandom_range(0, 5);
                    if (op == 5) op = 4;
                    a  = 32'h100 + 4 * $urandom_range(0, 2);
                    d  = $urandom;
                end
                drive(op, a, d, $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 4) == 0,
                      32'h100 + 4 * $urandom_range(0, 2));
                #3;
                model_step();
                tick();
            end
        end

        // HALT is sticky and freezes the pipe
        do_reset();
        drive(5, 0, 0, 0, 0, 0, 0);
        #3;
        chk("halt_det_mwen", mw_enable, 1);
        chk("halt_det_stall", stall_o, 0);
        chk("halt_det_halt", halt_o, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h100, 0, 1, 0, 0, 0);
            #3;
            chk("halted_halt", halt_o, 1);
            chk("halted_mwen", mw_enable, 0);
            chk("halted_stall", stall_o, 1);
            chk("halted_ren", dmem_ren, 0);
            tick();
        end

        // asynchronous reset in the middle of an LW access
        do_reset();
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        tick();
        #3;
        chk("mid_ren", dmem_ren, 1);
        tick();
        #3;
        chk("mid_wait", wait_cnt, 1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_ren", dmem_ren, 0);
        chk("mid_rst_wen", dmem_wen, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        nRST = 1'b1;
        #3;
        chk("post_halt", halt_o, 0);
        chk("post_acc", acc_cnt, 0);
        chk("post_wait", wait_cnt, 0);
        chk("post_mwen", mw_enable, 1);
        chk("post_ren", dmem_ren, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
